// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int CNT_W = 4;

    localparam logic GNT0 = 1'b0;
    localparam logic GNT1 = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_ACCESS = ST_ACCESS,
        S_DONE   = ST_DONE
    } state_t;

    function automatic logic other_gnt(input logic g);
        return (g == GNT0) ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signal bundle; slave = arbiter view, master = requesters + RAM view.
interface mem_bus_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          rdy0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          rdy1;
    logic [DW-1:0] rdata1;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output rdy0, rdata0, rdy1, rdata1,
        output mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  rdy0, rdata0, rdy1, rdata1,
        input  mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Combinational two-way winner pick; round-robin on ties, or fixed priority when ARB_FIXED_PRIO_EN is defined.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_gnt,
    output logic o_gnt,
    output logic o_valid
);

    assign o_valid = i_req0 | i_req1;

`ifdef ARB_FIXED_PRIO_EN
    // Requester 0 always wins; requester 1 can starve while req0 is held (intended for CPU-first systems).
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = i_last_gnt;
    assign o_gnt = i_req0 ? GNT0 : GNT1;
`else
    always_comb begin
        o_gnt = GNT0;
        if (i_req0 && i_req1) begin
            o_gnt = other_gnt(i_last_gnt);
        end else if (i_req1) begin
            o_gnt = GNT1;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one 8-bit RAM port between two requesters: IDLE -> ACCESS (ACC_CYCLES) -> DONE, rdy pulse after ACC_CYCLES+1 edges.
// Requests seen during ACCESS/DONE wait for the next IDLE; ARB_FIXED_PRIO_EN selects fixed priority in rr_pick2.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int ACC_CYCLES = 1   // legal range 1..15
)
(
    input  logic               i_clk,
    input  logic               i_rst,
    mem_bus_arbiter_if.slave   bus
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gnt;
    logic             r_last_gnt;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;
    logic             r_mem_we;
    logic             r_rdy0;
    logic             r_rdy1;
    logic [DW-1:0]    r_rdata0;
    logic [DW-1:0]    r_rdata1;
    logic             r_busy;

    logic             w_gnt;
    logic             w_valid;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_wdata;
    logic             w_sel_we;

    rr_pick2 u_pick (
        .i_req0     (bus.req0),
        .i_req1     (bus.req1),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_gnt),
        .o_valid    (w_valid)
    );

    assign w_sel_addr  = (w_gnt == GNT1) ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = (w_gnt == GNT1) ? bus.wdata1 : bus.wdata0;
    assign w_sel_we    = (w_gnt == GNT1) ? bus.we1    : bus.we0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_gnt       <= GNT0;
            r_last_gnt  <= GNT1;   // requester 0 wins the first tie
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_rdy0      <= 1'b0;
            r_rdy1      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_gnt       <= w_gnt;
                        r_last_gnt  <= w_gnt;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_we    <= w_sel_we;
                        r_cnt       <= CNT_W'(ACC_CYCLES - 1);
                        r_busy      <= 1'b1;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        // Write accesses leave the granted requester's rdata untouched.
                        if (r_gnt == GNT1) begin
                            r_rdy1 <= 1'b1;
                            if (!r_mem_we) r_rdata1 <= bus.mem_rdata;
                        end else begin
                            r_rdy0 <= 1'b1;
                            if (!r_mem_we) r_rdata0 <= bus.mem_rdata;
                        end
                        r_mem_we <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_rdy0  <= 1'b0;
                    r_rdy1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rdy0      = r_rdy0;
    assign bus.rdy1      = r_rdy1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: one instance with ACC_CYCLES=1 (directed + random traffic) and one with ACC_CYCLES=4.
module tb_mem_bus_arbiter;

    localparam int ACC_A = 1;
    localparam int ACC_B = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_bus_arbiter_if #(.AW(8), .DW(8)) ba ();
    mem_bus_arbiter_if #(.AW(8), .DW(8)) bb ();

    mem_bus_arbiter #(.AW(8), .DW(8), .ACC_CYCLES(ACC_A)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ba)
    );

    mem_bus_arbiter #(.AW(8), .DW(8), .ACC_CYCLES(ACC_B)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bb)
    );

    logic [7:0] seedmem [256];
    logic [7:0] rama    [256];
    logic [7:0] ramb    [256];

    // reference model state
    logic [7:0] m_mem   [256];
    logic [7:0] m_rdata [2];
    bit         m_last;

    assign ba.mem_rdata = rama[ba.mem_addr];
    assign bb.mem_rdata = ramb[bb.mem_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                rama[i] <= seedmem[i];
                ramb[i] <= seedmem[i];
            end
        end else begin
            if (ba.mem_we) rama[ba.mem_addr] <= ba.mem_wdata;
            if (bb.mem_we) ramb[bb.mem_addr] <= bb.mem_wdata;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last     = 1'b1;
        m_rdata[0] = 8'h00;
        m_rdata[1] = 8'h00;
        m_mem      = seedmem;
    endtask

    task automatic chk_rst(input string tag, input logic rdy0, input logic rdy1,
                           input logic [7:0] rd0, input logic [7:0] rd1,
                           input logic [7:0] ma, input logic [7:0] mw,
                           input logic we, input logic busy);
        chk({tag, "_rdy"},   {rdy1, rdy0}, 0);
        chk({tag, "_rdata"}, {rd1, rd0},   0);
        chk({tag, "_maddr"}, ma,           0);
        chk({tag, "_mwdat"}, mw,           0);
        chk({tag, "_mwe"},   we,           0);
        chk({tag, "_busy"},  busy,         0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ba.req0 = 0; ba.we0 = 0; ba.addr0 = 0; ba.wdata0 = 0;
        ba.req1 = 0; ba.we1 = 0; ba.addr1 = 0; ba.wdata1 = 0;
        bb.req0 = 0; bb.we0 = 0; bb.addr0 = 0; bb.wdata0 = 0;
        bb.req1 = 0; bb.we1 = 0; bb.addr1 = 0; bb.wdata1 = 0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One transaction on instance A, starting with the DUT idle.
    task automatic txn(input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [7:0] a0, input logic [7:0] d0,
                       input logic [7:0] a1, input logic [7:0] d1,
                       input bit keep, input bit drop_mid, input string tag);
        bit         win;
        bit         ww;
        logic [7:0] wa;
        logic [7:0] wd;
        logic       rdy_w;
        logic       rdy_o;
        bit         got;
        int         lat;
        ba.req0 = r0; ba.we0 = w0; ba.addr0 = a0; ba.wdata0 = d0;
        ba.req1 = r1; ba.we1 = w1; ba.addr1 = a1; ba.wdata1 = d1;
        if (r0 && r1) begin
`ifdef ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = !m_last;
`endif
        end else begin
            win = !r0;
        end
        m_last = win;
        ww = win ? w1 : w0;
        wa = win ? a1 : a0;
        wd = win ? d1 : d0;
        if (!ww) m_rdata[win] = m_mem[wa];
        got = 0;
        lat = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            tick();
            if (c == 1) begin
                if (win) begin
                    if (drop_mid) ba.req1 = 0;
                    ba.addr1 = 8'($urandom); ba.wdata1 = 8'($urandom);
                end else begin
                    if (drop_mid) ba.req0 = 0;
                    ba.addr0 = 8'($urandom); ba.wdata0 = 8'($urandom);
                end
            end
            rdy_w = win ? ba.rdy1 : ba.rdy0;
            rdy_o = win ? ba.rdy0 : ba.rdy1;
            chk({tag, "_other_rdy"}, rdy_o, 0);
            if (rdy_w) begin
                got = 1;
                lat = c;
            end else begin
                chk({tag, "_maddr"}, ba.mem_addr, wa);
                chk({tag, "_mwe"},   ba.mem_we,   ww);
                if (ww) chk({tag, "_mwdat"}, ba.mem_wdata, wd);
                chk({tag, "_busy"},  ba.busy,     1);
            end
        end
        chk({tag, "_lat"},      lat,        ACC_A + 1);
        chk({tag, "_rdata_w"},  win ? ba.rdata1 : ba.rdata0, m_rdata[win]);
        chk({tag, "_rdata_o"},  win ? ba.rdata0 : ba.rdata1, m_rdata[!win]);
        chk({tag, "_done_mwe"}, ba.mem_we,  0);
        chk({tag, "_done_bsy"}, ba.busy,    1);
        if (ww) m_mem[wa] = wd;
        if (!keep) begin
            if (win) ba.req1 = 0; else ba.req0 = 0;
        end
        tick();
        chk({tag, "_idle_rdy"},  {ba.rdy1, ba.rdy0}, 0);
        chk({tag, "_idle_busy"}, ba.busy,            0);
    endtask

    // Read on instance B (ACC_CYCLES=4), starting with B idle.
    task automatic b_read(input logic [7:0] a, input string tag);
        bit got;
        int lat;
        got = 0;
        lat = 0;
        bb.req0 = 1; bb.we0 = 0; bb.addr0 = a;
        for (int c = 1; c <= 20 && !got; c++) begin
            tick();
            if (bb.rdy0) begin
                got = 1;
                lat = c;
            end else begin
                chk({tag, "_maddr"}, bb.mem_addr, a);
                chk({tag, "_busy"},  bb.busy,     1);
            end
        end
        chk({tag, "_lat"},   lat,       ACC_B + 1);
        chk({tag, "_rdata"}, bb.rdata0, seedmem[a]);
        bb.req0 = 0;
        tick();
        chk({tag, "_idle_rdy"}, bb.rdy0, 0);
    endtask

    initial begin
        bit         r0;
        bit         r1;
        logic [7:0] ra;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) seedmem[i] = 8'($urandom);
        seedmem[8'h20] = 8'h5A;

        do_reset();
        chk_rst("rst_a", ba.rdy0, ba.rdy1, ba.rdata0, ba.rdata1, ba.mem_addr, ba.mem_wdata, ba.mem_we, ba.busy);
        chk_rst("rst_b", bb.rdy0, bb.rdy1, bb.rdata0, bb.rdata1, bb.mem_addr, bb.mem_wdata, bb.mem_we, bb.busy);

        // single read, single write, read-back
        txn(1, 0, 0, 0, 8'h20, 8'h00, 8'h00, 8'h00, 0, 0, "rd20");
        chk("rd20_const", ba.rdata0, 8'h5A);
        txn(0, 1, 0, 1, 8'h00, 8'h00, 8'h30, 8'hC3, 0, 0, "wr30");
        txn(1, 0, 0, 0, 8'h30, 8'h00, 8'h00, 8'h00, 0, 0, "rd30");
        chk("rd30_const", ba.rdata0, 8'hC3);

        // both requests held continuously from reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            txn(1, 1, 0, 0, 8'(8'h40 + k), 8'h00, 8'(8'h50 + k), 8'h00, 1, 0, "tie");
        end
        ba.req0 = 0;
        ba.req1 = 0;
        tick();

        // winner drops req after grant while the other waits
        txn(1, 1, 0, 1, 8'h21, 8'h00, 8'h31, 8'h77, 0, 1, "drop");
        txn(0, 1, 0, 1, 8'h00, 8'h00, 8'h31, 8'h77, 0, 0, "pend");
        txn(1, 0, 0, 0, 8'h31, 8'h00, 8'h00, 8'h00, 0, 0, "rd31");

        // random traffic over a small address window
        for (int k = 0; k < 40; k++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1;
            txn(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {4'h6, 4'($urandom)}, 8'($urandom), {4'h6, 4'($urandom)}, 8'($urandom),
                0, ($urandom_range(0, 3) == 0), "rnd");
        end

        // longer access on instance B
        b_read(8'h44, "b_rd44");

        // reset during the 2nd access cycle of a write
        bb.req1 = 1; bb.we1 = 1; bb.addr1 = 8'h55; bb.wdata1 = 8'h99;
        tick();
        chk("b_wr_acc1_mwe",   bb.mem_we,   1);
        chk("b_wr_acc1_maddr", bb.mem_addr, 8'h55);
        tick();
        chk("b_wr_acc2_mwe",   bb.mem_we,   1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bb.req1 = 0;
        model_reset();
        chk_rst("b_midrst", bb.rdy0, bb.rdy1, bb.rdata0, bb.rdata1, bb.mem_addr, bb.mem_wdata, bb.mem_we, bb.busy);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("b_midrst_no_rdy", {bb.rdy1, bb.rdy0}, 0);
        end
        b_read(8'h55, "b_rd55");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
